// File: rtl/aes_round_key_store.sv
// Round-key buffer behind the AES-256 key expander. Captures the key stream
// once and replays it in ascending (encrypt) or descending (decrypt) order.
module aes_round_key_store #(
    parameter int KEY_W    = 128,
    parameter int NUM_KEYS = 15,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             keys_ready,
    output logic             load_err,
    input  logic             rd_start,
    input  logic             rd_dir,
    output logic [KEY_W-1:0] rk_out,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_valid,
    output logic             rk_last,
    input  logic             rk_ack
);

    localparam logic [IDX_W:0]   P_FULL    = (IDX_W+1)'(NUM_KEYS);
    localparam logic [IDX_W:0]   P_FULL_M1 = (IDX_W+1)'(NUM_KEYS - 1);
    localparam logic [IDX_W:0]   P_PTR_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] P_LAST    = IDX_W'(NUM_KEYS - 1);
    localparam logic [IDX_W-1:0] P_IDX_ONE = IDX_W'(1);

    typedef enum logic {ST_IDLE, ST_SERVE} state_t;

    state_t           r_state, w_state_next;
    logic [KEY_W-1:0] r_mem [NUM_KEYS];
    logic [IDX_W:0]   r_wr_ptr;
    logic             r_keys_ready, r_load_err;
    logic             r_dir, r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [KEY_W-1:0] r_rk_out;

    logic             w_full, w_we, w_last;
    logic [IDX_W-1:0] w_waddr;
    logic             w_dir_next, w_valid_next, w_rd_en;
    logic [IDX_W-1:0] w_idx_next;

    // load_start restarts the schedule, so a coincident key goes to entry 0
    assign w_full  = (r_wr_ptr == P_FULL);
    assign w_we    = key_valid && (load_start || !w_full);
    assign w_waddr = load_start ? '0 : r_wr_ptr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= key_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_keys_ready <= 1'b0;
            r_load_err   <= 1'b0;
        end else if (load_start) begin
            r_wr_ptr     <= key_valid ? P_PTR_ONE : '0;
            r_keys_ready <= 1'b0;
            r_load_err   <= 1'b0;
        end else if (key_valid) begin
            if (w_full) begin
                r_load_err <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr + P_PTR_ONE;
                if (r_wr_ptr == P_FULL_M1) begin
                    r_keys_ready <= 1'b1;
                end
            end
        end
    end

    assign w_last = r_valid && (r_dir ? (r_idx == '0) : (r_idx == P_LAST));

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_dir_next   = r_dir;
        w_valid_next = r_valid;
        w_rd_en      = 1'b0;
        if (load_start) begin
            w_state_next = ST_IDLE;
            w_valid_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rd_start && r_keys_ready) begin
                        w_state_next = ST_SERVE;
                        w_valid_next = 1'b1;
                        w_dir_next   = rd_dir;
                        w_idx_next   = rd_dir ? P_LAST : '0;
                        w_rd_en      = 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (rk_ack) begin
                        if (w_last) begin
                            w_state_next = ST_IDLE;
                            w_valid_next = 1'b0;
                        end else begin
                            w_idx_next = r_dir ? (r_idx - P_IDX_ONE) : (r_idx + P_IDX_ONE);
                            w_rd_en    = 1'b1;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_dir    <= 1'b0;
            r_valid  <= 1'b0;
            r_rk_out <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_dir   <= w_dir_next;
            r_valid <= w_valid_next;
            if (w_rd_en) begin
                r_rk_out <= r_mem[w_idx_next];
            end
        end
    end

    assign keys_ready = r_keys_ready;
    assign load_err   = r_load_err;
    assign rk_out     = r_rk_out;
    assign rk_idx     = r_idx;
    assign rk_valid   = r_valid;
    assign rk_last    = w_last;

endmodule

// File: tb/tb_aes_round_key_store.sv
// Bench for aes_round_key_store: table of load/replay scenarios checked
// against a scoreboard of expected beats, plus abort and async-reset cases.
module tb_aes_round_key_store;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_start, key_valid, rd_start, rd_dir, rk_ack;
    logic [127:0] key_in;
    logic         keys_ready, load_err, rk_valid, rk_last;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    aes_round_key_store dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .keys_ready (keys_ready),
        .load_err   (load_err),
        .rd_start   (rd_start),
        .rd_dir     (rd_dir),
        .rk_out     (rk_out),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_last    (rk_last),
        .rk_ack     (rk_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nload;
        bit merge;
        bit dir;
        int gap;
        bit poke;
        bit exp_ready;
        bit exp_err;
        bit exp_serve;
    } vec_t;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         last;
    } beat_t;

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [127:0] model [15];
    beat_t        sb [$];
    vec_t         tbl [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    function automatic logic [127:0] mk_key(input int row, input int i);
        logic [3:0]   n;
        logic [127:0] k;
        n = 4'(i);
        k = {32{n}};
        if (row != 0) k = k ^ {$urandom, $urandom, $urandom, $urandom};
        return k;
    endfunction

    task automatic load_keys(input int row, input int n, input bit merge);
        int first;
        first = 0;
        @(negedge clk);
        load_start = 1'b1;
        if (merge) begin
            key_in    = mk_key(row, 0);
            model[0]  = key_in;
            key_valid = 1'b1;
            first     = 1;
        end
        @(negedge clk);
        load_start = 1'b0;
        key_valid  = 1'b0;
        chk("ready_cleared", keys_ready, 1'b0);
        chk("err_cleared", load_err, 1'b0);
        for (int i = first; i < n; i++) begin
            key_in = mk_key(row, i);
            if (i < 15) model[i] = key_in;
            key_valid = 1'b1;
            @(negedge clk);
        end
        key_valid = 1'b0;
    endtask

    task automatic serve(input bit dir, input int gap, input bit poke, input bit exp_serve);
        int    cyc;
        int    nvalid;
        beat_t b;
        sb.delete();
        if (exp_serve) begin
            for (int j = 0; j < 15; j++) begin
                b.idx  = dir ? 4'(14 - j) : 4'(j);
                b.key  = model[b.idx];
                b.last = (j == 14);
                sb.push_back(b);
            end
        end
        rd_dir   = dir;
        rd_start = 1'b1;
        rk_ack   = 1'b0;
        @(negedge clk);
        rd_start = 1'b0;
        cyc      = 0;
        nvalid   = 0;
        while ((sb.size() > 0 || rk_valid) && cyc < 300) begin
            rk_ack   = ((cyc % gap) == gap - 1);
            rd_start = poke && (sb.size() > 1);
            rd_dir   = ~dir;
            if (rk_valid) begin
                nvalid++;
                if (sb.size() == 0) begin
                    chk("extra_beat", rk_valid, 1'b0);
                end else begin
                    chk("rk_idx", rk_idx, sb[0].idx);
                    chk("rk_out", rk_out, sb[0].key);
                    chk("rk_last", rk_last, sb[0].last);
                    if (rk_ack) void'(sb.pop_front());
                end
            end
            @(negedge clk);
            cyc++;
        end
        rk_ack   = 1'b0;
        rd_start = 1'b0;
        rd_dir   = dir;
        if (cyc >= 300) chk("serve_timeout", 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("valid_after", rk_valid, 1'b0);
        chk("last_after", rk_last, 1'b0);
        if (exp_serve && gap == 1) chk("no_bubble", nvalid, 15);
    endtask

    task automatic run_row(input vec_t v, input int row);
        load_keys(row, v.nload, v.merge);
        chk("keys_ready", keys_ready, v.exp_ready);
        chk("load_err", load_err, v.exp_err);
        serve(v.dir, v.gap, v.poke, v.exp_serve);
    endtask

    initial begin
        int   cyc;
        vec_t rv;
        tbl[0] = '{15, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{15, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{15, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{10, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{15, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{14, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{17, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{15, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1};

        reset      = 1'b0;
        load_start = 1'b0;
        key_valid  = 1'b0;
        key_in     = '0;
        rd_start   = 1'b0;
        rd_dir     = 1'b0;
        rk_ack     = 1'b0;
        #3;
        chk("rst_keys_ready", keys_ready, 1'b0);
        chk("rst_load_err", load_err, 1'b0);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk_last", rk_last, 1'b0);
        chk("rst_rk_idx", rk_idx, 4'd0);
        chk("rst_rk_out", rk_out, 128'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < 9; r++) run_row(tbl[r], r);

        // Abort a replay with load_start while idx 5 is on the output
        load_keys(20, 15, 1'b0);
        rd_dir   = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        rk_ack   = 1'b1;
        cyc      = 0;
        while (!(rk_valid && rk_idx == 4'd5) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_idx5", rk_idx, 4'd5);
        rk_ack     = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("abort_rk_valid", rk_valid, 1'b0);
        chk("abort_keys_ready", keys_ready, 1'b0);
        rv = '{15, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1};
        run_row(rv, 21);

        // Asynchronous reset in the middle of a replay, then mid-load
        load_keys(22, 15, 1'b0);
        rd_dir   = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        rk_ack   = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rk_valid", rk_valid, 1'b0);
        chk("async_keys_ready", keys_ready, 1'b0);
        chk("async_rk_idx", rk_idx, 4'd0);
        chk("async_rk_out", rk_out, 128'd0);
        rk_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        load_keys(23, 7, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midload_keys_ready", keys_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        rv = '{15, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b1};
        run_row(rv, 24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
